// File: rtl/huff_decoder.sv
// ----------------------------------------------------------------------------
// huff_decoder
//
// Serial Huffman decoder. A code table of MAX_CHAR_COUNT entries
// {symbol, code, mask} is loaded after a tbl_load pulse. A bitstream is then
// consumed one bit per accepted handshake, MSB of each code first. Every
// completed codeword produces one symbol on a valid/ready output. While a
// symbol waits for the sink, no further bits are accepted.
//
// Optional feature (macro HUFF_DEC_ERR_EN):
//   defined   -> adds code_err (one-cycle pulse per invalid code) and
//                err_cnt (4-bit saturating count of invalid codes)
//   undefined -> invalid codes are flushed silently
//
// Ports
//   clk        clock
//   reset_n    asynchronous active-low reset
//   tbl_load   pulse: clear the table and start loading (highest priority)
//   tbl_valid  table entry present (used only while loading)
//   tbl_sym    entry symbol
//   tbl_code   entry code value, first-sent bit at [len-1]
//   tbl_mask   (1<<len)-1, zero marks an unused entry
//   bit_valid  stream bit present
//   bit_in     stream bit
//   bit_ready  decoder can take a bit this cycle
//   sym_valid  decoded symbol present
//   sym_out    decoded symbol
//   sym_ready  sink accepts the symbol
//   tbl_done   table loaded, decoder is decoding or emitting
//   code_err   (HUFF_DEC_ERR_EN) invalid-code pulse
//   err_cnt    (HUFF_DEC_ERR_EN) saturating invalid-code count
// ----------------------------------------------------------------------------
module huff_decoder #(
    parameter int MAX_CHAR_COUNT = 3,
    parameter int CODE_W         = 3,
    parameter int SYM_W          = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tbl_load,
    input  logic              tbl_valid,
    input  logic [SYM_W-1:0]  tbl_sym,
    input  logic [CODE_W-1:0] tbl_code,
    input  logic [CODE_W-1:0] tbl_mask,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic              bit_ready,
    output logic              sym_valid,
    output logic [SYM_W-1:0]  sym_out,
    input  logic              sym_ready,
    output logic              tbl_done
`ifdef HUFF_DEC_ERR_EN
    ,
    output logic              code_err,
    output logic [3:0]        err_cnt
`endif
);

    localparam int IDX_W = (MAX_CHAR_COUNT > 1) ? $clog2(MAX_CHAR_COUNT) : 1;
    localparam int LEN_W = $clog2(CODE_W + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MAX_CHAR_COUNT - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(CODE_W);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EMIT   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CODE_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [SYM_W-1:0]  tab_sym_q  [MAX_CHAR_COUNT];
    logic [SYM_W-1:0]  tab_sym_d  [MAX_CHAR_COUNT];
    logic [CODE_W-1:0] tab_code_q [MAX_CHAR_COUNT];
    logic [CODE_W-1:0] tab_code_d [MAX_CHAR_COUNT];
    logic [CODE_W-1:0] tab_mask_q [MAX_CHAR_COUNT];
    logic [CODE_W-1:0] tab_mask_d [MAX_CHAR_COUNT];
    logic              sym_valid_q, sym_valid_d;
    logic [SYM_W-1:0]  sym_out_q, sym_out_d;
`ifdef HUFF_DEC_ERR_EN
    logic              code_err_q, code_err_d;
    logic [3:0]        err_cnt_q, err_cnt_d;
`endif

    // Candidate accumulator/length if the current bit is taken, and the
    // lowest-index table entry matching that candidate.
    logic [CODE_W:0]   shift_w;
    logic [CODE_W-1:0] acc_n;
    logic [LEN_W-1:0]  len_n;
    logic [CODE_W-1:0] want_mask;
    logic              hit;
    logic [SYM_W-1:0]  hit_sym;

    always_comb begin
        shift_w   = {acc_q, bit_in};
        acc_n     = shift_w[CODE_W-1:0];
        len_n     = len_q + LEN_W'(1);
        want_mask = '0;
        for (int b = 0; b < CODE_W; b++) begin
            want_mask[b] = (b < int'(len_n));
        end
        hit     = 1'b0;
        hit_sym = '0;
        // Scan from the top so the lowest matching index is the one kept.
        for (int i = MAX_CHAR_COUNT - 1; i >= 0; i--) begin
            if ((tab_mask_q[i] != '0) && (tab_mask_q[i] == want_mask) &&
                (tab_code_q[i] == acc_n)) begin
                hit     = 1'b1;
                hit_sym = tab_sym_q[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        len_d       = len_q;
        tab_sym_d   = tab_sym_q;
        tab_code_d  = tab_code_q;
        tab_mask_d  = tab_mask_q;
        sym_valid_d = sym_valid_q;
        sym_out_d   = sym_out_q;
`ifdef HUFF_DEC_ERR_EN
        code_err_d  = 1'b0;
        err_cnt_d   = err_cnt_q;
`endif
        if (tbl_load) begin
            // Restart from an empty table; any pending symbol is dropped.
            state_d     = ST_LOAD;
            idx_d       = '0;
            acc_d       = '0;
            len_d       = '0;
            sym_valid_d = 1'b0;
            for (int i = 0; i < MAX_CHAR_COUNT; i++) begin
                tab_sym_d[i]  = '0;
                tab_code_d[i] = '0;
                tab_mask_d[i] = '0;
            end
`ifdef HUFF_DEC_ERR_EN
            err_cnt_d   = '0;
`endif
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (tbl_valid) begin
                        tab_sym_d[idx_q]  = tbl_sym;
                        tab_code_d[idx_q] = tbl_code;
                        tab_mask_d[idx_q] = tbl_mask;
                        if (idx_q == IDX_LAST) begin
                            idx_d   = '0;
                            state_d = ST_DECODE;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                ST_DECODE: begin
                    if (bit_valid) begin
                        if (hit) begin
                            sym_out_d   = hit_sym;
                            sym_valid_d = 1'b1;
                            acc_d       = '0;
                            len_d       = '0;
                            state_d     = ST_EMIT;
                        end else if (len_n == LEN_MAX) begin
                            // Longest code length reached without a match.
                            acc_d = '0;
                            len_d = '0;
`ifdef HUFF_DEC_ERR_EN
                            code_err_d = 1'b1;
                            if (err_cnt_q != 4'hf) begin
                                err_cnt_d = err_cnt_q + 4'd1;
                            end
`endif
                        end else begin
                            acc_d = acc_n;
                            len_d = len_n;
                        end
                    end
                end
                ST_EMIT: begin
                    if (sym_ready) begin
                        sym_valid_d = 1'b0;
                        state_d     = ST_DECODE;
                    end
                end
                default: begin
                    state_d = ST_LOAD;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_LOAD;
            idx_q       <= '0;
            acc_q       <= '0;
            len_q       <= '0;
            sym_valid_q <= 1'b0;
            sym_out_q   <= '0;
            for (int i = 0; i < MAX_CHAR_COUNT; i++) begin
                tab_sym_q[i]  <= '0;
                tab_code_q[i] <= '0;
                tab_mask_q[i] <= '0;
            end
`ifdef HUFF_DEC_ERR_EN
            code_err_q  <= 1'b0;
            err_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            len_q       <= len_d;
            sym_valid_q <= sym_valid_d;
            sym_out_q   <= sym_out_d;
            tab_sym_q   <= tab_sym_d;
            tab_code_q  <= tab_code_d;
            tab_mask_q  <= tab_mask_d;
`ifdef HUFF_DEC_ERR_EN
            code_err_q  <= code_err_d;
            err_cnt_q   <= err_cnt_d;
`endif
        end
    end

    // Ready and done follow the state register directly so an asynchronous
    // reset drops them without waiting for a clock edge.
    assign bit_ready = (state_q == ST_DECODE);
    assign tbl_done  = (state_q != ST_LOAD);
    assign sym_valid = sym_valid_q;
    assign sym_out   = sym_out_q;
`ifdef HUFF_DEC_ERR_EN
    assign code_err  = code_err_q;
    assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_huff_decoder.sv
// ----------------------------------------------------------------------------
// tb_huff_decoder
//
// Testbench for huff_decoder. A behavioural model keeps the table as plain
// arrays and the partial code as an integer value plus a bit count; each
// cycle the DUT outputs are compared against the model, then new inputs are
// driven and the model advanced for the coming edge. Directed scenarios
// cover the listed cases, followed by randomized tables and streams.
// Build with +define+HUFF_DEC_ERR_EN to also check code_err/err_cnt.
// ----------------------------------------------------------------------------
module tb_huff_decoder;

    localparam int MAXC = 3;

    logic       clk;
    logic       reset_n;
    logic       tbl_load;
    logic       tbl_valid;
    logic [7:0] tbl_sym;
    logic [2:0] tbl_code;
    logic [2:0] tbl_mask;
    logic       bit_valid;
    logic       bit_in;
    logic       bit_ready;
    logic       sym_valid;
    logic [7:0] sym_out;
    logic       sym_ready;
    logic       tbl_done;
`ifdef HUFF_DEC_ERR_EN
    logic       code_err;
    logic [3:0] err_cnt;
`endif

    huff_decoder #(
        .MAX_CHAR_COUNT (MAXC),
        .CODE_W         (3),
        .SYM_W          (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .tbl_load  (tbl_load),
        .tbl_valid (tbl_valid),
        .tbl_sym   (tbl_sym),
        .tbl_code  (tbl_code),
        .tbl_mask  (tbl_mask),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .bit_ready (bit_ready),
        .sym_valid (sym_valid),
        .sym_out   (sym_out),
        .sym_ready (sym_ready),
        .tbl_done  (tbl_done)
`ifdef HUFF_DEC_ERR_EN
        ,
        .code_err  (code_err),
        .err_cnt   (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    int   t_sym [MAXC];
    int   t_code[MAXC];
    int   t_mask[MAXC];
    int   n_sym [MAXC];
    int   n_code[MAXC];
    int   n_mask[MAXC];
    int   m_val;
    int   m_len;
    bit   m_loaded;
    bit   m_pending;
    int   m_sym;
    bit   m_err;
    int   m_cnt;

    bit   stream_q[$];
    int   got_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < MAXC; i++) begin
            t_sym[i] = 0; t_code[i] = 0; t_mask[i] = 0;
        end
        m_val = 0; m_len = 0; m_loaded = 0; m_pending = 0;
        m_sym = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic check_outputs();
        chk("bit_ready", 32'(bit_ready), 32'(m_loaded && !m_pending));
        chk("sym_valid", 32'(sym_valid), 32'(m_pending));
        chk("sym_out",   32'(sym_out),   32'(m_sym));
        chk("tbl_done",  32'(tbl_done),  32'(m_loaded));
`ifdef HUFF_DEC_ERR_EN
        chk("code_err",  32'(code_err),  32'(m_err));
        chk("err_cnt",   32'(err_cnt),   32'(m_cnt));
`endif
    endtask

    // Called at a negedge: check, drive inputs, advance model, move to next negedge.
    task automatic step(input logic bv, input logic bi, input logic sr, output logic accepted);
        int hit;
        check_outputs();
        if (sym_valid && sr) got_q.push_back(int'(sym_out));
        tbl_load  = 1'b0;
        tbl_valid = 1'b0;
        bit_valid = bv;
        bit_in    = bi;
        sym_ready = sr;
        accepted  = m_loaded && !m_pending && bv;
        m_err     = 0;
        if (m_loaded && m_pending) begin
            if (sr) m_pending = 0;
        end else if (accepted) begin
            m_val = m_val * 2 + int'(bi);
            m_len = m_len + 1;
            hit = -1;
            for (int i = 0; i < MAXC; i++) begin
                if (hit < 0 && t_mask[i] != 0 && t_mask[i] == (1 << m_len) - 1 &&
                    t_code[i] == m_val) hit = i;
            end
            if (hit >= 0) begin
                m_pending = 1;
                m_sym     = t_sym[hit];
                m_val     = 0;
                m_len     = 0;
            end else if (m_len == 3) begin
                m_val = 0;
                m_len = 0;
                m_err = 1;
                if (m_cnt < 15) m_cnt++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_table();
        int ng;
        check_outputs();
        tbl_load  = 1'b1;
        tbl_valid = 1'($urandom);
        tbl_sym   = 8'($urandom);
        tbl_code  = 3'($urandom);
        tbl_mask  = 3'($urandom);
        bit_valid = 1'($urandom);
        bit_in    = 1'($urandom);
        sym_ready = 1'($urandom);
        for (int i = 0; i < MAXC; i++) begin
            t_sym[i] = 0; t_code[i] = 0; t_mask[i] = 0;
        end
        m_val = 0; m_len = 0; m_loaded = 0; m_pending = 0; m_err = 0; m_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        tbl_load = 1'b0;
        for (int k = 0; k < MAXC; k++) begin
            ng = int'($urandom_range(0, 2));
            for (int g = 0; g < ng; g++) begin
                check_outputs();
                tbl_valid = 1'b0;
                bit_valid = 1'($urandom);
                bit_in    = 1'($urandom);
                @(posedge clk);
                @(negedge clk);
            end
            check_outputs();
            tbl_valid = 1'b1;
            tbl_sym   = 8'(n_sym[k]);
            tbl_code  = 3'(n_code[k]);
            tbl_mask  = 3'(n_mask[k]);
            bit_valid = 1'($urandom);
            bit_in    = 1'($urandom);
            t_sym[k] = n_sym[k]; t_code[k] = n_code[k]; t_mask[k] = n_mask[k];
            if (k == MAXC - 1) m_loaded = 1;
            @(posedge clk);
            @(negedge clk);
        end
        tbl_valid = 1'b0;
        bit_valid = 1'b0;
    endtask

    task automatic feed(input logic sr, input bit stop_on_sym);
        int   budget;
        logic acc;
        budget = 200;
        while (stream_q.size() > 0) begin
            if (stop_on_sym && m_pending) break;
            if (budget == 0) begin
                chk("feed_budget", 32'd0, 32'd1);
                break;
            end
            budget--;
            step(1'b1, stream_q[0], sr, acc);
            if (acc) void'(stream_q.pop_front());
        end
    endtask

    task automatic drain(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, acc);
    endtask

    task automatic set_abc();
        n_sym[0] = 'h61; n_code[0] = 0; n_mask[0] = 1;
        n_sym[1] = 'h62; n_code[1] = 2; n_mask[1] = 3;
        n_sym[2] = 'h63; n_code[2] = 3; n_mask[2] = 3;
    endtask

    task automatic async_reset_now();
        reset_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic acc;
        int   len;

        reset_n   = 1'b1;
        tbl_load  = 1'b0; tbl_valid = 1'b0; tbl_sym = '0; tbl_code = '0; tbl_mask = '0;
        bit_valid = 1'b0; bit_in = 1'b0; sym_ready = 1'b0;
        #2;
        reset_n = 1'b0;
        model_reset();
        #10;
        check_outputs();
        @(negedge clk);
        reset_n = 1'b1;

        // Basic decode: 0 | 10 | 11 -> a, b, c
        set_abc();
        load_table();
        chk("t1_tbl_done", 32'(tbl_done), 32'd1);
        got_q.delete();
        stream_q = '{0, 1, 0, 1, 1};
        feed(1'b1, 1'b0);
        drain(3);
        chk("t1_count", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            chk("t1_sym0", 32'(got_q[0]), 32'h61);
            chk("t1_sym1", 32'(got_q[1]), 32'h62);
            chk("t1_sym2", 32'(got_q[2]), 32'h63);
        end

        // Backpressure: hold sym_ready low after the first symbol
        got_q.delete();
        stream_q = '{0, 1, 0, 1, 1};
        feed(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'($urandom), 1'b0, acc);
            chk("t2_hold_sym", 32'(sym_out), 32'h61);
            chk("t2_hold_rdy", 32'(bit_ready), 32'd0);
        end
        feed(1'b1, 1'b0);
        drain(3);
        chk("t2_count", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            chk("t2_sym0", 32'(got_q[0]), 32'h61);
            chk("t2_sym2", 32'(got_q[2]), 32'h63);
        end

        // Invalid code 111 with an unused third entry
        n_sym[0] = 'h61; n_code[0] = 0; n_mask[0] = 1;
        n_sym[1] = 'h62; n_code[1] = 2; n_mask[1] = 3;
        n_sym[2] = 'h63; n_code[2] = 3; n_mask[2] = 0;
        load_table();
        got_q.delete();
        stream_q = '{1, 1, 1};
        feed(1'b1, 1'b0);
        chk("t3_no_sym", 32'(sym_valid), 32'd0);
`ifdef HUFF_DEC_ERR_EN
        chk("t3_code_err", 32'(code_err), 32'd1);
        chk("t3_err_cnt",  32'(err_cnt),  32'd1);
`endif
        drain(2);
        chk("t3_none_out", 32'(got_q.size()), 32'd0);

        // tbl_load mid-code discards the partial prefix
        set_abc();
        load_table();
        step(1'b1, 1'b1, 1'b1, acc);
        chk("t4_bit_acc", 32'(acc), 32'd1);
        load_table();
        got_q.delete();
        stream_q = '{0};
        feed(1'b1, 1'b0);
        drain(2);
        chk("t4_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() == 1) chk("t4_sym", 32'(got_q[0]), 32'h61);

        // Asynchronous reset while a symbol is pending
        stream_q = '{0};
        feed(1'b0, 1'b1);
        chk("t5_pending", 32'(sym_valid), 32'd1);
        @(negedge clk);
        #1;
        async_reset_now();
        chk("t5_state_load", 32'(tbl_done), 32'd0);

        // Duplicate entries: lowest index wins
        n_sym[0] = 'h41; n_code[0] = 0; n_mask[0] = 1;
        n_sym[1] = 'h42; n_code[1] = 0; n_mask[1] = 1;
        n_sym[2] = 'h63; n_code[2] = 3; n_mask[2] = 3;
        load_table();
        got_q.delete();
        stream_q = '{0};
        feed(1'b1, 1'b0);
        drain(2);
        chk("t6_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() == 1) chk("t6_sym", 32'(got_q[0]), 32'h41);

        // Randomized tables and streams with random handshakes
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < MAXC; i++) begin
                len       = int'($urandom_range(1, 3));
                n_mask[i] = (1 << len) - 1;
                n_code[i] = int'($urandom) & n_mask[i];
                n_sym[i]  = int'($urandom_range(0, 255));
                if ($urandom_range(0, 3) == 0) n_mask[i] = 0;
            end
            load_table();
            for (int c = 0; c < 250; c++) begin
                step(1'($urandom_range(0, 9) < 7), 1'($urandom),
                     1'($urandom_range(0, 9) < 6), acc);
            end
        end

        // Empty table: every 3 bits is an invalid code, counter saturates
        for (int i = 0; i < MAXC; i++) begin
            n_sym[i] = int'($urandom_range(0, 255)); n_code[i] = 0; n_mask[i] = 0;
        end
        load_table();
        for (int c = 0; c < 60; c++) step(1'b1, 1'($urandom), 1'b1, acc);
`ifdef HUFF_DEC_ERR_EN
        chk("sat_err_cnt", 32'(err_cnt), 32'd15);
`endif
        chk("empty_no_sym", 32'(sym_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
